// File: rtl/mips_16_defs.sv
// Shared definitions for the mips_16 execute stage: ALU command codes, packet layouts, datapath width.
// EX_ITER_DIV_EN selects whether ALU_DIV is an iterative divide or a NOP.
package mips_16_defs;

  localparam int DW    = 16;
  localparam int CNT_W = 4;

  localparam logic [3:0] ALU_NOP = 4'd0;
  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4;
  localparam logic [3:0] ALU_XOR = 4'd5;
  localparam logic [3:0] ALU_SL  = 4'd6;
  localparam logic [3:0] ALU_SR  = 4'd7;
  localparam logic [3:0] ALU_SRU = 4'd8;
  localparam logic [3:0] ALU_MUL = 4'd9;
  localparam logic [3:0] ALU_DIV = 4'd10;

  // ID->EX packet: {alu_cmd, src1, src2, mem/wb fields}
  localparam int ID_W       = 58;
  localparam int ID_CMD_LSB = 54;
  localparam int ID_SRC1_LSB = 38;
  localparam int ID_SRC2_LSB = 22;
  localparam int PASS_W     = 22;

  // EX->MEM packet: {alu_result, mem/wb fields}
  localparam int EX_W       = 38;
  localparam int EX_RES_LSB = 22;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DW - 1);

  typedef enum logic {ST_IDLE, ST_BUSY} ex_state_e;
  typedef enum logic {MD_MUL, MD_DIV} md_op_e;

  function automatic logic is_iter_op(input logic [3:0] cmd);
`ifdef EX_ITER_DIV_EN
    return (cmd == ALU_MUL) || (cmd == ALU_DIV);
`else
    return cmd == ALU_MUL;
`endif
  endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Shift-add multiplier / restoring divider datapath, one bit per step; the caller owns the counter.
// result_o is the value after the current step, so the final step's result is usable on its own edge.
module iter_muldiv
  import mips_16_defs::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  md_op_e           op_i,
  input  logic [DW-1:0]    a_i,
  input  logic [DW-1:0]    b_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             step_i,
  output logic             done_o,
  output logic [DW-1:0]    result_o
);

  // mcand_q: multiplicand (MUL) or dividend (DIV), shifted left each step.
  // mplr_q: multiplier (MUL) or divisor (DIV). acc_q: product or quotient.
  logic [DW-1:0] mcand_q, mplr_q, acc_q;
  logic [DW-1:0] acc_d, mul_acc;

`ifdef EX_ITER_DIV_EN
  md_op_e        op_q;
  logic [DW-1:0] rem_q, rem_d, diff;
  logic [DW:0]   trial;
  logic          ge;
`else
  logic unused_op;
  assign unused_op = op_i;
`endif

  always_comb begin
    mul_acc = acc_q + (mplr_q[cnt_i] ? mcand_q : '0);
    acc_d   = mul_acc;
`ifdef EX_ITER_DIV_EN
    rem_d = rem_q;
    trial = {rem_q, mcand_q[DW-1]};
    ge    = trial >= {1'b0, mplr_q};
    // When ge holds the true difference is below the divisor, so 16 bits suffice.
    diff  = trial[DW-1:0] - mplr_q;
    if (op_q == MD_DIV) begin
      acc_d = {acc_q[DW-2:0], ge};
      rem_d = ge ? diff : trial[DW-1:0];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
`ifdef EX_ITER_DIV_EN
      rem_q   <= '0;
      op_q    <= MD_MUL;
`endif
    end else if (start_i) begin
      mcand_q <= a_i;
      mplr_q  <= b_i;
      acc_q   <= '0;
`ifdef EX_ITER_DIV_EN
      rem_q   <= '0;
      op_q    <= op_i;
`endif
    end else if (step_i) begin
      mcand_q <= mcand_q << 1;
      acc_q   <= acc_d;
`ifdef EX_ITER_DIV_EN
      rem_q   <= rem_d;
`endif
    end
  end

  assign done_o   = step_i && (cnt_i == LAST_CNT);
  assign result_o = acc_d;

endmodule

// File: rtl/ex_stage_iter.sv
// mips_16 execute stage: 1-edge ALU ops; MUL (and DIV with EX_ITER_DIV_EN) take 17 edges,
// stalling ID for 16 cycles and sending all-zero bubbles to MEM until the result beat.
module ex_stage_iter
  import mips_16_defs::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [ID_W-1:0] pipeline_reg_in,
  output logic [EX_W-1:0] pipeline_reg_out,
  output logic            stall_out,
  output logic [2:0]      ex_op_dest
);

  logic [3:0]        alu_cmd;
  logic [DW-1:0]     src1, src2, alu_res;
  logic [PASS_W-1:0] pass_fields;
  logic [3:0]        shamt;
  logic              iter_op;

  ex_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PASS_W-1:0] hold_q, hold_d;
  logic [EX_W-1:0]   out_q, out_d;

  logic              md_start, md_step, md_done;
  logic [DW-1:0]     md_result;
  md_op_e            md_op;

  assign alu_cmd     = pipeline_reg_in[ID_CMD_LSB +: 4];
  assign src1        = pipeline_reg_in[ID_SRC1_LSB +: DW];
  assign src2        = pipeline_reg_in[ID_SRC2_LSB +: DW];
  assign pass_fields = pipeline_reg_in[PASS_W-1:0];
  assign shamt       = src2[3:0];
  assign iter_op     = is_iter_op(alu_cmd);
  assign md_op       = (alu_cmd == ALU_DIV) ? MD_DIV : MD_MUL;
  assign ex_op_dest  = pipeline_reg_in[3:1];

  // MUL/DIV fall into the default here; the iterative unit supplies their results.
  always_comb begin
    alu_res = '0;
    case (alu_cmd)
      ALU_ADD: alu_res = src1 + src2;
      ALU_SUB: alu_res = src1 - src2;
      ALU_AND: alu_res = src1 & src2;
      ALU_OR:  alu_res = src1 | src2;
      ALU_XOR: alu_res = src1 ^ src2;
      ALU_SL:  alu_res = src1 << shamt;
      ALU_SR:  alu_res = $signed(src1) >>> shamt;
      ALU_SRU: alu_res = src1 >> shamt;
      default: alu_res = '0;
    endcase
  end

  assign md_step = (state_q == ST_BUSY);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    out_d     = '0;
    md_start  = 1'b0;
    stall_out = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (iter_op) begin
          stall_out = 1'b1;
          md_start  = 1'b1;
          hold_d    = pass_fields;
          cnt_d     = '0;
          state_d   = ST_BUSY;
        end else begin
          out_d = {alu_res, pass_fields};
        end
      end
      ST_BUSY: begin
        // Stall drops in the final cycle so ID advances on the same edge the result lands.
        if (md_done) begin
          out_d   = {md_result, hold_q};
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          stall_out = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      out_q   <= out_d;
    end
  end

  assign pipeline_reg_out = out_q;

  iter_muldiv u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .start_i  (md_start),
    .op_i     (md_op),
    .a_i      (src1),
    .b_i      (src2),
    .cnt_i    (cnt_q),
    .step_i   (md_step),
    .done_o   (md_done),
    .result_o (md_result)
  );

endmodule
